// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding word memory responder with LAT wait states
//            and a one-cycle ready pulse. Optional macro: DMEM_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         c_AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAT = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [c_AW-1:0] r_idx;
  logic            r_mis;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [c_AW-1:0] w_idx;
  logic            w_mis;
  logic            w_unused;

  assign w_idx = addr[c_AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis    = |addr[1:0];
  assign w_unused = ^addr[31:c_AW+2];
`else
  assign w_mis    = 1'b0;
  assign w_unused = ^{addr[31:c_AW+2], addr[1:0]};
`endif

  // Outputs are registered from the next state so they line up with RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_wdata <= 32'h0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_idx   <= w_idx;
            r_mis   <= w_mis;
            r_wdata <= wdata;
            r_cnt   <= c_LAT;
            busy    <= 1'b1;
            if (c_LAT != 4'd0) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_RESP;
              ready   <= 1'b1;
              err     <= w_mis;
              if (!we) rdata <= w_mis ? 32'h0 : r_mem[w_idx];
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            ready   <= 1'b1;
            err     <= r_mis;
            if (!r_we) rdata <= r_mis ? 32'h0 : r_mem[r_idx];
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset; an async reset drops RESP so a pending store is lost.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_we && !r_mis) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the far side of the ARM datapath's load/store port. It accepts one word request at a time (address from the ALU result, store data from the shifter output), inserts a programmable number of wait states, then returns read data with a one-cycle `ready` pulse. It replaces the zero-latency combinational data memory so the core and its control FSM can be exercised against realistic memory latency.

## Interface
- `DEPTH_WORDS`, 64, number of 32-bit words in the array; power of two, ≥ 4.
- `LAT`, 2, wait-state cycles inserted between acceptance and response; range 0–15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  1  request valid; sampled only in IDLE.
- `we`  input  1  1 = store, 0 = load; captured with `req`.
- `addr`  input  32  byte address; word index = `addr[AW+1:2]`, where AW = log2(`DEPTH_WORDS`).
- `wdata`  input  32  store data; captured with `req`.
- `busy`  output  1  high in WAIT and RESP.
- `ready`  output  1  single-cycle completion pulse.
- `rdata`  output  32  load result; holds its value between loads.
- `err`  output  1  alignment error flag; valid while `ready` = 1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `req` = 1: capture `we`, `addr`, `wdata` into holding registers and load counter `cnt` with `LAT`.
  - Next state is WAIT if `LAT` > 0, otherwise RESP.
  - On `req` = 0: remain in IDLE.
- **WAIT**
  - Decrement `cnt` each cycle.
  - Go to RESP on the edge where `cnt` = 1.
  - `req`, `we`, `addr` and `wdata` are ignored.
- **RESP**
  - `ready` = 1 for exactly this one cycle.
  - Load: `rdata` was registered on the edge entering RESP, from `mem[captured index]`.
  - Store: `mem[captured index]` is written on the edge leaving RESP.
  - Next state is always IDLE.
  - A new `req` is accepted no earlier than the cycle after RESP.
- **Addressing**
  - Addresses beyond the array wrap modulo `DEPTH_WORDS`.
  - `addr[31:AW+2]` is ignored.
- **Array and reset**
  - The memory array is not cleared by reset; its contents are X until first written, unless preloaded by the bench.
- **Reset mid-operation**
  - State returns to IDLE; `ready`, `busy` and `err` go to 0; `rdata` goes to 0.
  - A store in progress is abandoned: the array is unmodified.

## Timing
- Reset values: state IDLE, `cnt` 0, `busy` 0, `ready` 0, `err` 0, `rdata` 32'h0.
- Acceptance edge is edge 0 and `ready` is high in cycle `LAT`+1.
  - `LAT` = 0: `ready` is high the cycle after acceptance.
  - `LAT` = 2: `ready` is high 3 cycles after acceptance.
- Throughput: one request per `LAT`+2 cycles.
- `busy` rises the cycle after acceptance and falls with the cycle after RESP.
- Load followed immediately by a store to the same word (accepted after RESP): the load returns the old value.
- Back-to-back: a store then a load to the same word returns the new value, because the write completes before the next acceptance.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined**
  - If captured `addr[1:0]` ≠ 0, `err` = 1 during RESP.
  - A misaligned store is suppressed (array unchanged).
  - A misaligned load returns 32'h0 in `rdata`.
  - `err` = 0 in all other cycles.
- **Undefined**
  - `addr[1:0]` is ignored and `err` is tied to 0.
  - Misaligned accesses act on the containing word.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → `busy`/`ready`/`err` = 0 and `rdata` = 0 immediately, without waiting for a clock edge.
- **Store/load round trip** (`LAT` = 2): store 32'hDEADBEEF to 0x10, then load 0x10 → each `ready` arrives exactly 3 cycles after acceptance; load `rdata` = 32'hDEADBEEF.
- **Request during busy:** toggle `req` while in WAIT with `addr` = 0x20 → no extra acceptance; only one `ready` pulse; mem[0x20] unchanged.
- **Wrap** (`DEPTH_WORDS` = 64): store 32'h12345678 to 0x100 → load from 0x000 returns 32'h12345678.
- **Alignment** (`DMEM_ALIGN_CHECK_EN` defined): store to 0x13 → `err` = 1 with `ready` and word 0x10 unchanged; load from 0x13 → `rdata` = 0 and `err` = 1.
- **Reset during store:** reset in WAIT of a store of 32'hA5A5A5A5 to 0x08 holding 32'h1 → reload of 0x08 after reset returns 32'h1.
